riscv_core_muldiv_issue: RTL and testbench

- Requester-side controller for the pipelined mul/div unit.
- Accepts decoded M-extension ops from the X stage and drives the muldivreq handshake.
- Tracks in-flight destination registers in order, consumes muldivresp, selects the correct 32-bit half, and produces a registered writeback.
- Exports a scoreboard busy mask for the core's hazard logic.

---
 rtl/riscv_core_muldiv_issue.sv | 179 +++++++++++++++++
 tb/tb_riscv_core_muldiv_issue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_muldiv_issue.sv
// Requester-side issue/writeback controller for the pipelined mul/div unit.
// Optional perf counters enabled by defining RISCV_MULDIV_ISSUE_PERF_EN.
module riscv_core_muldiv_issue #(
  parameter int MAX_INFLIGHT = 4,
  parameter int RD_W         = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_val,
  output logic            issue_rdy,
  input  logic [2:0]      issue_fn,
  input  logic [31:0]     issue_a,
  input  logic [31:0]     issue_b,
  input  logic [RD_W-1:0] issue_rd,
  output logic            muldivreq_val,
  input  logic            muldivreq_rdy,
  output logic [2:0]      muldivreq_msg_fn,
  output logic [31:0]     muldivreq_msg_a,
  output logic [31:0]     muldivreq_msg_b,
  input  logic            muldivresp_val,
  output logic            muldivresp_rdy,
  input  logic [63:0]     muldivresp_msg_result,
  output logic            wb_val,
  input  logic            wb_rdy,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic [31:0]     busy_mask,
  output logic            proto_err,
  output logic [31:0]     perf_issue_cnt,
  output logic [31:0]     perf_stall_cnt
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_DIV    = 3'd1,
    FN_DIVU   = 3'd2,
    FN_REM    = 3'd3,
    FN_REMU   = 3'd4,
    FN_MULH   = 3'd5,
    FN_MULHSU = 3'd6,
    FN_MULHU  = 3'd7
  } fn_e;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            hi_sel;
  } tag_t;

  // The unit packs MUL/DIV/DIVU results in the low word, everything else high.
  function automatic logic fn_hi_sel(input logic [2:0] fn);
    case (fn_e'(fn))
      FN_MUL, FN_DIV, FN_DIVU: return 1'b0;
      default:                 return 1'b1;
    endcase
  endfunction

  tag_t             tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wb_val_q, wb_val_d;
  logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [31:0]      busy_q, busy_d;
  logic             proto_err_q, proto_err_d;

  logic hold, fire, resp_fire, pop, wb_fire;
  tag_t head;

  // Hold looks at the current count only; a same-cycle pop does not free a slot.
  assign hold = (count_q == FULL_CNT) || ((issue_rd != '0) && busy_q[issue_rd]);

  assign issue_rdy        = muldivreq_rdy & ~hold;
  assign muldivreq_val    = issue_val & ~hold;
  assign muldivreq_msg_fn = issue_fn;
  assign muldivreq_msg_a  = issue_a;
  assign muldivreq_msg_b  = issue_b;

  assign fire           = issue_val & issue_rdy;
  assign muldivresp_rdy = ~wb_val_q | wb_rdy;
  assign resp_fire      = muldivresp_val & muldivresp_rdy;
  assign pop            = resp_fire & (count_q != '0);
  assign wb_fire        = wb_val_q & wb_rdy;
  assign head           = tag_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wb_val_d    = wb_val_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    busy_d      = busy_q;
    proto_err_d = proto_err_q;

    if (fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({fire, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (resp_fire && (count_q == '0)) proto_err_d = 1'b1;

    // Writes to x0 are popped but never reach the regfile.
    if (pop && (head.rd != '0)) begin
      wb_val_d  = 1'b1;
      wb_rd_d   = head.rd;
      wb_data_d = head.hi_sel ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0];
    end else if (wb_fire) begin
      wb_val_d  = 1'b0;
    end

    if (wb_fire) busy_d[wb_rd_q] = 1'b0;
    if (fire && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wb_val_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      busy_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wb_val_q    <= wb_val_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: tag storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr_q] <= '{rd: issue_rd, hi_sel: fn_hi_sel(issue_fn)};
  end

  assign wb_val    = wb_val_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign busy_mask = busy_q;
  assign proto_err = proto_err_q;

`ifdef RISCV_MULDIV_ISSUE_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire)                    perf_issue_q <= perf_issue_q + 32'd1;
      if (issue_val && !issue_rdy) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_core_muldiv_issue.sv
// Randomized bench for riscv_core_muldiv_issue: a queue-based reference model
// plus a behavioural mul/div unit that computes RISC-V M results arithmetically.
module tb_riscv_core_muldiv_issue;

  localparam int MAX_INFLIGHT = 4;
  localparam int RD_W         = 5;

  logic            clk;
  logic            reset;
  logic            issue_val;
  logic            issue_rdy;
  logic [2:0]      issue_fn;
  logic [31:0]     issue_a;
  logic [31:0]     issue_b;
  logic [RD_W-1:0] issue_rd;
  logic            muldivreq_val;
  logic            muldivreq_rdy;
  logic [2:0]      muldivreq_msg_fn;
  logic [31:0]     muldivreq_msg_a;
  logic [31:0]     muldivreq_msg_b;
  logic            muldivresp_val;
  logic            muldivresp_rdy;
  logic [63:0]     muldivresp_msg_result;
  logic            wb_val;
  logic            wb_rdy;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic [31:0]     busy_mask;
  logic            proto_err;
  logic [31:0]     perf_issue_cnt;
  logic [31:0]     perf_stall_cnt;

  riscv_core_muldiv_issue #(.MAX_INFLIGHT(MAX_INFLIGHT), .RD_W(RD_W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .issue_val             (issue_val),
    .issue_rdy             (issue_rdy),
    .issue_fn              (issue_fn),
    .issue_a               (issue_a),
    .issue_b               (issue_b),
    .issue_rd              (issue_rd),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .wb_rd                 (wb_rd),
    .wb_data               (wb_data),
    .busy_mask             (busy_mask),
    .proto_err             (proto_err),
    .perf_issue_cnt        (perf_issue_cnt),
    .perf_stall_cnt        (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // RISC-V M-extension result for one op, from the ISA definition.
  function automatic logic [31:0] isa_result(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd5: begin p = sa * sb; return p[63:32]; end
      3'd6: begin p = sa * ub; return p[63:32]; end
      3'd7: begin p = ua * ub; return p[63:32]; end
      3'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd3: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      3'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // The unit puts MUL/DIV/DIVU results in the low word; the other word is junk.
  function automatic logic [63:0] unit_pack(input logic [2:0] fn, input logic [31:0] r);
    logic [31:0] junk;
    junk = $urandom;
    return (fn <= 3'd2) ? {junk, r} : {r, junk};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
  } op_t;

  op_t             inflight [$];   // ops the controller should be tracking, oldest first
  logic [63:0]     resp_q   [$];   // results held by the behavioural unit, oldest first
  logic [31:0]     exp_busy;
  logic            exp_wb_val;
  logic [RD_W-1:0] exp_wb_rd;
  logic [31:0]     exp_wb_data;
  logic            exp_proto;
  logic [31:0]     exp_icnt, exp_scnt;
  int              hit_full = 0, hit_waw = 0, hit_proto = 0, hit_bp = 0, n_wb = 0;

  always @(negedge clk) begin
    logic            hold_m, rdy_m, rrdy_m, fire_m, rfire_m, wfire_m, popped;
    logic [RD_W-1:0] old_wb_rd;
    op_t             head;
    logic [63:0]     dummy;
    if (reset) begin
      inflight.delete();
      exp_busy    = '0;
      exp_wb_val  = 1'b0;
      exp_wb_rd   = '0;
      exp_wb_data = '0;
      exp_proto   = 1'b0;
      exp_icnt    = '0;
      exp_scnt    = '0;
    end else begin
      hold_m = (inflight.size() == MAX_INFLIGHT) || (issue_rd != 0 && exp_busy[issue_rd]);
      rdy_m  = muldivreq_rdy && !hold_m;
      rrdy_m = !exp_wb_val || wb_rdy;

      check("issue_rdy", issue_rdy, rdy_m);
      check("req_val", muldivreq_val, issue_val && !hold_m);
      check("req_msg", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b},
            {issue_fn, issue_a, issue_b});
      check("resp_rdy", muldivresp_rdy, rrdy_m);
      check("wb_val", wb_val, exp_wb_val);
      check("wb_rd", wb_rd, exp_wb_rd);
      check("wb_data", wb_data, exp_wb_data);
      check("busy_mask", busy_mask, exp_busy);
      check("proto_err", proto_err, exp_proto);
`ifdef RISCV_MULDIV_ISSUE_PERF_EN
      check("perf_issue", perf_issue_cnt, exp_icnt);
      check("perf_stall", perf_stall_cnt, exp_scnt);
`else
      check("perf_issue", perf_issue_cnt, 0);
      check("perf_stall", perf_stall_cnt, 0);
`endif

      if (issue_val && inflight.size() == MAX_INFLIGHT) hit_full++;
      if (issue_val && inflight.size() < MAX_INFLIGHT && issue_rd != 0 && exp_busy[issue_rd]) hit_waw++;
      if (exp_wb_val && !wb_rdy && muldivresp_val) hit_bp++;

      fire_m    = issue_val && rdy_m;
      rfire_m   = muldivresp_val && rrdy_m;
      wfire_m   = exp_wb_val && wb_rdy;
      old_wb_rd = exp_wb_rd;
      popped    = 1'b0;
      head      = '0;
      if (wfire_m) n_wb++;

      if (issue_val && !rdy_m) exp_scnt++;

      if (rfire_m) begin
        if (resp_q.size() > 0) dummy = resp_q.pop_front();
        if (inflight.size() > 0) begin
          head   = inflight.pop_front();
          popped = 1'b1;
        end else begin
          exp_proto = 1'b1;
          hit_proto++;
        end
      end

      if (fire_m) begin
        exp_icnt++;
        inflight.push_back('{rd: issue_rd, data: isa_result(issue_fn, issue_a, issue_b)});
        resp_q.push_back(unit_pack(issue_fn, isa_result(issue_fn, issue_a, issue_b)));
      end

      if (popped && head.rd != 0) begin
        exp_wb_val  = 1'b1;
        exp_wb_rd   = head.rd;
        exp_wb_data = head.data;
      end else if (wfire_m) begin
        exp_wb_val  = 1'b0;
      end

      if (wfire_m) exp_busy[old_wb_rd] = 1'b0;
      if (fire_m && issue_rd != 0) exp_busy[issue_rd] = 1'b1;
    end
  end

  task automatic drive_one(input int issue_pct, input int req_pct, input int resp_pct,
                           input int wbrdy_pct);
    @(posedge clk);
    #1;
    issue_val     = ($urandom_range(99) < issue_pct);
    issue_fn      = 3'($urandom_range(7));
    issue_a       = rand_operand();
    issue_b       = rand_operand();
    issue_rd      = RD_W'($urandom_range(7));
    muldivreq_rdy = ($urandom_range(99) < req_pct);
    wb_rdy        = ($urandom_range(99) < wbrdy_pct);
    if (resp_q.size() > 0 && $urandom_range(99) < resp_pct) begin
      muldivresp_val        = 1'b1;
      muldivresp_msg_result = resp_q[0];
    end else begin
      muldivresp_val        = 1'b0;
      muldivresp_msg_result = {$urandom, $urandom};
    end
  endtask

  task automatic hold_reset(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      reset          = 1'b1;
      issue_val      = 1'b0;
      muldivresp_val = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset                 = 1'b1;
    issue_val             = 1'b0;
    issue_fn              = '0;
    issue_a               = '0;
    issue_b               = '0;
    issue_rd              = '0;
    muldivreq_rdy         = 1'b0;
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = '0;
    wb_rdy                = 1'b0;
    hold_reset(3);

    repeat (400) drive_one(70, 80, 60, 80);   // balanced traffic
    repeat (400) drive_one(90, 95, 10, 90);   // slow unit: fills the tag FIFO
    repeat (400) drive_one(70, 80, 80, 20);   // writeback backpressure

    // Reset with ops in flight; the unit keeps its results and returns them later.
    n = 0;
    while (inflight.size() < 2 && n < 200) begin
      drive_one(90, 95, 0, 50);
      n++;
    end
    check("inflight_before_reset", inflight.size() >= 2, 1);
    hold_reset(2);
    n = 0;
    while (resp_q.size() > 0 && n < 200) begin
      drive_one(0, 80, 60, 80);
      n++;
    end
    check("stale_resp_drain", resp_q.size(), 0);

    repeat (400) drive_one(60, 80, 60, 70);

    n = 0;
    while ((resp_q.size() > 0 || inflight.size() > 0 || exp_wb_val) && n < 300) begin
      drive_one(0, 80, 80, 100);
      n++;
    end
    check("final_drain", inflight.size() + resp_q.size(), 0);
    drive_one(0, 80, 0, 100);
    @(negedge clk);

    check("cov_fifo_full_hold", hit_full != 0, 1);
    check("cov_waw_hold", hit_waw != 0, 1);
    check("cov_stale_response", hit_proto != 0, 1);
    check("cov_resp_backpressure", hit_bp != 0, 1);
    check("cov_writebacks", n_wb > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
